// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: runs LR.W / SC.W / AMO*.W as a read-modify-write on the
// data-memory port while stalling the pipeline, and tracks the single LR/SC reservation.
module amo_sequencer #(
    parameter int XLEN     = 32,
    parameter int RESV_LSB = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            amo_valid,
    input  logic [4:0]      amo_funct5,
    input  logic [XLEN-1:0] amo_addr,
    input  logic [XLEN-1:0] amo_rs2,
    input  logic [4:0]      amo_rd_addr,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            snoop_valid,
    input  logic [XLEN-1:0] snoop_addr,
    output logic            amo_stall,
    output logic            wb_we,
    output logic [4:0]      wb_rd_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            amo_illegal,
    output logic            amo_misaligned,
    output logic            resv_valid
);

    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    localparam logic [XLEN-1:0] GRAN_MASK = {{(XLEN-RESV_LSB){1'b1}}, {RESV_LSB{1'b0}}};
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

    state_t          state_r;
    logic [4:0]      funct5_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] rs2_r;
    logic [XLEN-1:0] old_r;
    logic [XLEN-1:0] resv_addr_r;
    logic            resv_valid_r;

    logic            resv_set_s;
    logic            sc_clear_s;
    logic [XLEN-1:0] resv_cmp_addr_s;
    logic            snoop_hit_s;
    logic            sc_hit_s;
    logic            busy_s;

    function automatic logic is_legal(input logic [4:0] f);
        case (f)
            F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_AND, F_OR,
            F_MIN, F_MAX, F_MINU, F_MAXU: is_legal = 1'b1;
            default:                      is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] amo_alu(input logic [4:0] f,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        case (f)
            F_SWAP, F_SC: amo_alu = b;
            F_ADD:        amo_alu = a + b;
            F_XOR:        amo_alu = a ^ b;
            F_AND:        amo_alu = a & b;
            F_OR:         amo_alu = a | b;
            F_MIN:        amo_alu = ($signed(a) < $signed(b)) ? a : b;
            F_MAX:        amo_alu = ($signed(a) > $signed(b)) ? a : b;
            F_MINU:       amo_alu = (a < b) ? a : b;
            F_MAXU:       amo_alu = (a > b) ? a : b;
            default:      amo_alu = a;
        endcase
    endfunction

    // A snoop that coincides with an LR completing is compared against the address being reserved.
    assign resv_set_s      = (state_r == RD_WAIT) && mem_rvalid && (funct5_r == F_LR);
    assign sc_clear_s      = (state_r == IDLE) && amo_valid && (amo_funct5 == F_SC);
    assign resv_cmp_addr_s = resv_set_s ? addr_r : resv_addr_r;
    assign snoop_hit_s     = snoop_valid && (((snoop_addr ^ resv_cmp_addr_s) & GRAN_MASK) == {XLEN{1'b0}});
    assign sc_hit_s        = resv_valid_r && (((amo_addr ^ resv_addr_r) & GRAN_MASK) == {XLEN{1'b0}});
    assign busy_s          = (state_r == RD_REQ) || (state_r == RD_WAIT) ||
                             (state_r == WR_REQ) || (state_r == WR_WAIT);
    assign amo_stall       = rst_n && (((state_r == IDLE) && amo_valid) || busy_s);
    assign resv_valid      = resv_valid_r;

    // Reservation register: clear (snoop hit or SC issue) takes priority over an LR set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid_r <= 1'b0;
            resv_addr_r  <= {XLEN{1'b0}};
        end else if (snoop_hit_s || sc_clear_s) begin
            resv_valid_r <= 1'b0;
        end else if (resv_set_s) begin
            resv_valid_r <= 1'b1;
            resv_addr_r  <= addr_r;
        end
    end

    // Sequencer FSM with registered memory-port and writeback outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            funct5_r       <= 5'd0;
            addr_r         <= {XLEN{1'b0}};
            rs2_r          <= {XLEN{1'b0}};
            old_r          <= {XLEN{1'b0}};
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= {XLEN{1'b0}};
            mem_wdata      <= {XLEN{1'b0}};
            wb_we          <= 1'b0;
            wb_rd_addr     <= 5'd0;
            wb_data        <= {XLEN{1'b0}};
            amo_illegal    <= 1'b0;
            amo_misaligned <= 1'b0;
        end else begin
            wb_we          <= 1'b0;
            amo_illegal    <= 1'b0;
            amo_misaligned <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (amo_valid) begin
                        funct5_r   <= amo_funct5;
                        addr_r     <= amo_addr;
                        rs2_r      <= amo_rs2;
                        wb_rd_addr <= amo_rd_addr;
                        mem_addr   <= amo_addr & WORD_MASK;
                        if (amo_addr[1:0] != 2'b00) begin
                            amo_misaligned <= 1'b1;
                            state_r        <= DONE;
                        end else if (!is_legal(amo_funct5)) begin
                            amo_illegal <= 1'b1;
                            state_r     <= DONE;
                        end else if (amo_funct5 == F_SC) begin
                            if (sc_hit_s) begin
                                mem_req   <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_wdata <= amo_rs2;
                                state_r   <= WR_REQ;
                            end else begin
                                wb_we   <= 1'b1;
                                wb_data <= {{(XLEN-1){1'b0}}, 1'b1};
                                state_r <= DONE;
                            end
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            state_r <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        old_r <= mem_rdata;
                        if (funct5_r == F_LR) begin
                            wb_we   <= 1'b1;
                            wb_data <= mem_rdata;
                            state_r <= DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= amo_alu(funct5_r, mem_rdata, rs2_r);
                            state_r   <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state_r <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (mem_rvalid) begin
                        wb_we   <= 1'b1;
                        wb_data <= (funct5_r == F_SC) ? {XLEN{1'b0}} : old_r;
                        state_r <= DONE;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer: a behavioural word memory with configurable grant and
// read-valid delays answers the memory port; each step checks hand-computed results.
module tb_amo_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        amo_valid = 1'b0;
    logic [4:0]  amo_funct5 = 5'd0;
    logic [31:0] amo_addr = 32'd0;
    logic [31:0] amo_rs2 = 32'd0;
    logic [4:0]  amo_rd_addr = 5'd0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        snoop_valid = 1'b0;
    logic [31:0] snoop_addr = 32'd0;
    logic        amo_stall, wb_we, amo_illegal, amo_misaligned, resv_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;

    amo_sequencer dut (
        .clk(clk), .rst_n(rst_n), .amo_valid(amo_valid), .amo_funct5(amo_funct5),
        .amo_addr(amo_addr), .amo_rs2(amo_rs2), .amo_rd_addr(amo_rd_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .amo_stall(amo_stall),
        .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .amo_illegal(amo_illegal), .amo_misaligned(amo_misaligned), .resv_valid(resv_valid)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] F_LR = 5'b00010, F_SC = 5'b00011, F_SWAP = 5'b00001;
    localparam logic [4:0] F_ADD = 5'b00000, F_XOR = 5'b00100, F_MIN = 5'b10000;
    localparam logic [4:0] F_MAXU = 5'b11100, F_BAD = 5'b11111;

    logic [31:0] mem [0:1023];
    int          gnt_delay = 0;
    int          rv_delay = 0;
    int          req_cycles = 0;
    int          write_count = 0;
    int          stab_err = 0;
    logic [31:0] last_wdata = 32'd0;

    int vectors = 0;
    int miscompares = 0;

    // Results of the most recent run_op.
    int          op_lat;
    logic        op_wb_we, op_ill, op_mis;
    logic [31:0] op_wb_data;
    logic [4:0]  op_rd;
    int          op_reqs, op_writes;

    // Memory responder: grant after gnt_delay waiting cycles, rvalid rv_delay cycles after the grant cycle.
    initial begin : responder
        bit          seen, rv_pending;
        int          gnt_wait, rv_wait;
        logic        cap_we;
        logic [31:0] cap_addr, cap_wdata, rd_value;
        seen = 1'b0; rv_pending = 1'b0; gnt_wait = 0; rv_wait = 0;
        cap_we = 1'b0; cap_addr = 32'd0; cap_wdata = 32'd0; rd_value = 32'd0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                seen = 1'b0;
                rv_pending = 1'b0;
            end else if (rv_pending) begin
                if (rv_wait == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_value;
                    rv_pending = 1'b0;
                end else begin
                    rv_wait--;
                end
            end else if (mem_req) begin
                req_cycles++;
                if (!seen) begin
                    seen = 1'b1; gnt_wait = gnt_delay;
                    cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
                end else if (mem_we !== cap_we || mem_addr !== cap_addr ||
                             (cap_we && mem_wdata !== cap_wdata)) begin
                    stab_err++;
                end
                if (gnt_wait == 0) begin
                    mem_gnt = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[11:2]] = mem_wdata;
                        last_wdata = mem_wdata;
                        write_count++;
                        rd_value = 32'd0;
                    end else begin
                        rd_value = mem[mem_addr[11:2]];
                    end
                    rv_pending = 1'b1; rv_wait = rv_delay; seen = 1'b0;
                end else begin
                    gnt_wait--;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction, hold it while stalled, capture the DONE-cycle outputs.
    task automatic run_op(input logic [4:0] f5, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [4:0] rd);
        int k;
        int req0, wr0;
        @(negedge clk);
        amo_valid = 1'b1; amo_funct5 = f5; amo_addr = addr; amo_rs2 = rs2; amo_rd_addr = rd;
        req0 = req_cycles; wr0 = write_count;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (amo_stall && k < 200);
        check("op_timeout", (k >= 200) ? 32'd1 : 32'd0, 32'd0);
        op_lat = k + 1;
        op_wb_we = wb_we; op_wb_data = wb_data; op_rd = wb_rd_addr;
        op_ill = amo_illegal; op_mis = amo_misaligned;
        op_reqs = req_cycles - req0; op_writes = write_count - wr0;
        amo_valid = 1'b0;
    endtask

    initial begin : stimulus
        int k;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = 32'h0000_0055;
        mem[32'h200 >> 2] = 32'hFFFF_FFFF;
        mem[32'h204 >> 2] = 32'h8000_0000;
        mem[32'h208 >> 2] = 32'h8000_0000;
        mem[32'h20C >> 2] = 32'h0000_1234;
        mem[32'h210 >> 2] = 32'h0000_F0F0;
        mem[32'h300 >> 2] = 32'h0000_0077;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_stall", {31'd0, amo_stall}, 32'd0);
        check("rst_resv", {31'd0, resv_valid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        rst_n = 1'b1;

        // LR then matching SC succeeds
        run_op(F_LR, 32'h100, 32'd0, 5'd5);
        check("lr_lat", op_lat, 32'd4);
        check("lr_wb_we", {31'd0, op_wb_we}, 32'd1);
        check("lr_wb_data", op_wb_data, 32'h55);
        check("lr_rd", {27'd0, op_rd}, 32'd5);
        check("lr_resv", {31'd0, resv_valid}, 32'd1);
        run_op(F_SC, 32'h100, 32'hAA, 5'd6);
        check("sc_lat", op_lat, 32'd4);
        check("sc_wb_data", op_wb_data, 32'd0);
        check("sc_wb_we", {31'd0, op_wb_we}, 32'd1);
        check("sc_mem", mem[32'h100 >> 2], 32'hAA);
        check("sc_writes", op_writes, 32'd1);
        check("sc_resv", {31'd0, resv_valid}, 32'd0);

        // LR, snoop to the same granule, SC fails without memory access
        run_op(F_LR, 32'h100, 32'd0, 5'd7);
        check("lr2_resv", {31'd0, resv_valid}, 32'd1);
        snoop_valid = 1'b1; snoop_addr = 32'h102;
        @(negedge clk);
        snoop_valid = 1'b0;
        check("snoop_clear", {31'd0, resv_valid}, 32'd0);
        run_op(F_SC, 32'h100, 32'h33, 5'd8);
        check("scf_lat", op_lat, 32'd2);
        check("scf_wb_data", op_wb_data, 32'd1);
        check("scf_wb_we", {31'd0, op_wb_we}, 32'd1);
        check("scf_no_req", op_reqs, 32'd0);
        check("scf_mem", mem[32'h100 >> 2], 32'hAA);

        // Snoop hit in the same cycle the LR sets the reservation: clear wins
        snoop_valid = 1'b1; snoop_addr = 32'h101;
        run_op(F_LR, 32'h100, 32'd0, 5'd9);
        snoop_valid = 1'b0;
        check("lr_snoop_wb", op_wb_data, 32'hAA);
        check("lr_snoop_resv", {31'd0, resv_valid}, 32'd0);

        // AMO arithmetic
        run_op(F_ADD, 32'h200, 32'd2, 5'd10);
        check("add_lat", op_lat, 32'd6);
        check("add_wb", op_wb_data, 32'hFFFF_FFFF);
        check("add_mem", mem[32'h200 >> 2], 32'h1);
        run_op(F_MIN, 32'h204, 32'd1, 5'd11);
        check("min_wdata", last_wdata, 32'h8000_0000);
        check("min_wb", op_wb_data, 32'h8000_0000);
        run_op(F_MAXU, 32'h208, 32'd1, 5'd12);
        check("maxu_wdata", last_wdata, 32'h8000_0000);
        run_op(F_XOR, 32'h210, 32'h00FF, 5'd13);
        check("xor_mem", mem[32'h210 >> 2], 32'h0000_F00F);
        check("xor_wb", op_wb_data, 32'h0000_F0F0);

        // AMOSWAP with slow grant and late read-valid
        gnt_delay = 5; rv_delay = 3;
        run_op(F_SWAP, 32'h20C, 32'hBEEF, 5'd14);
        gnt_delay = 0; rv_delay = 0;
        check("swap_lat", op_lat, 32'd22);
        check("swap_stable", stab_err, 32'd0);
        check("swap_writes", op_writes, 32'd1);
        check("swap_mem", mem[32'h20C >> 2], 32'hBEEF);
        check("swap_wb", op_wb_data, 32'h1234);

        // Error cases: no memory access, no writeback
        run_op(F_ADD, 32'h203, 32'd1, 5'd15);
        check("mis_pulse", {31'd0, op_mis}, 32'd1);
        check("mis_wb_we", {31'd0, op_wb_we}, 32'd0);
        check("mis_no_req", op_reqs, 32'd0);
        check("mis_lat", op_lat, 32'd2);
        run_op(F_BAD, 32'h200, 32'd1, 5'd16);
        check("ill_pulse", {31'd0, op_ill}, 32'd1);
        check("ill_mis", {31'd0, op_mis}, 32'd0);
        check("ill_wb_we", {31'd0, op_wb_we}, 32'd0);
        check("ill_no_req", op_reqs, 32'd0);

        // Reset asserted while waiting in WR_REQ
        run_op(F_LR, 32'h300, 32'd0, 5'd17);
        check("lr3_resv", {31'd0, resv_valid}, 32'd1);
        gnt_delay = 6;
        @(negedge clk);
        amo_valid = 1'b1; amo_funct5 = F_ADD; amo_addr = 32'h200; amo_rs2 = 32'd5; amo_rd_addr = 5'd18;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(mem_req && mem_we) && k < 100);
        check("wrreq_timeout", (k >= 100) ? 32'd1 : 32'd0, 32'd0);
        rst_n = 1'b0; amo_valid = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_stall", {31'd0, amo_stall}, 32'd0);
        check("mid_rst_resv", {31'd0, resv_valid}, 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        gnt_delay = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_mem", mem[32'h200 >> 2], 32'h1);
        run_op(F_LR, 32'h100, 32'd0, 5'd19);
        check("post_lr_lat", op_lat, 32'd4);
        check("post_lr_wb", op_wb_data, 32'hAA);
        check("post_lr_resv", {31'd0, resv_valid}, 32'd1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
